// File: rtl/pipe_pkg.sv
// Shared types and helpers for the IF/ID pipeline buffer.
//   ifid_entry_t  : one fetched entry {pc, instr, hit} at the default widths
//   NOP_INSTR_DEF : instruction presented to decode while the buffer is empty
//   clog2         : ceiling log2 for sizing pointers and counters
package pipe_pkg;

    localparam int unsigned DEF_PC_W    = 32;
    localparam int unsigned DEF_INSTR_W = 32;

    localparam logic [DEF_INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_PC_W-1:0]    pc;
        logic [DEF_INSTR_W-1:0] instr;
        logic                   hit;
    } ifid_entry_t;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(v)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ifid_entry_ram.sv
// Entry storage for the IF/ID buffer: register array, one write port,
// one combinational read port. Storage is intentionally not reset.
//   clk   : clock, writes on negedge
//   we    : write enable
//   waddr : write slot
//   wdata : packed entry to store
//   raddr : read slot
//   rdata : packed entry at raddr (combinational)
module ifid_entry_ram #(
    parameter int unsigned W  = 65,
    parameter int unsigned AW = 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    // Sized to the full pointer range; slots at or above DEPTH are never
    // addressed and are trimmed by synthesis.
    localparam int unsigned SLOTS = 1 << AW;

    logic [W-1:0] mem_q [SLOTS];

    always_ff @(negedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ifid_pipe_buf.sv
// IF/ID pipeline buffer: up to DEPTH fetched entries between fetch and decode,
// valid/ready on both sides, flush on redirect, NOP to decode when empty.
// All state updates on negedge clk; asynchronous active-low reset.
// Optional build macro IFID_PERF_CNT_EN adds saturating stall/bubble counters.
//   in_valid/in_ready      : fetch-side handshake (in_ready = count != DEPTH)
//   next_pc/instruction/hit: fetched entry
//   flush                  : discard all entries, drop concurrent input
//   out_valid/out_ready    : decode-side handshake
//   next_pc_out/instruction_out/hit_out : registered head entry
//   stall_cnt/bubble_cnt   : (IFID_PERF_CNT_EN only) performance counters
module ifid_pipe_buf
    import pipe_pkg::*;
#(
    parameter int unsigned          PC_W      = DEF_PC_W,
    parameter int unsigned          INSTR_W   = DEF_INSTR_W,
    parameter int unsigned          DEPTH     = 2,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    next_pc,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               hit,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    next_pc_out,
    output logic [INSTR_W-1:0] instruction_out,
`ifdef IFID_PERF_CNT_EN
    output logic [31:0]        stall_cnt,
    output logic [31:0]        bubble_cnt,
`endif
    output logic               hit_out
);

    localparam int unsigned AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int unsigned CW = clog2(DEPTH + 1);
    localparam int unsigned EW = PC_W + INSTR_W + 1;

    logic [CW-1:0]      count_q, count_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               hit_q, hit_d;

    logic               push;
    logic               pop;
    logic [EW-1:0]      wr_entry;
    logic [EW-1:0]      rd_entry;

    // Ready depends on occupancy only, so a full buffer never accepts on a pop.
    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = out_valid_q & out_ready;
    assign wr_entry = {next_pc, instruction, hit};

    ifid_entry_ram #(
        .W  (EW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_d),
        .rdata (rd_entry)
    );

    // Next occupancy, pointers and head registers.
    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        hit_d       = hit_q;

        if (flush) begin
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            instr_d     = NOP_INSTR;
            hit_d       = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);

            if (count_d == '0) begin
                // Bubble: NOP to decode, next_pc_out keeps its last value.
                out_valid_d = 1'b0;
                instr_d     = NOP_INSTR;
                hit_d       = 1'b0;
            end else if (push && (count_q == CW'(pop))) begin
                // Incoming entry becomes head immediately; RAM write not visible yet.
                out_valid_d = 1'b1;
                pc_d        = next_pc;
                instr_d     = instruction;
                hit_d       = hit;
            end else begin
                out_valid_d = 1'b1;
                pc_d        = rd_entry[EW-1 -: PC_W];
                instr_d     = rd_entry[1 +: INSTR_W];
                hit_d       = rd_entry[0];
            end
        end
    end

    // State and output registers.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            instr_q     <= NOP_INSTR;
            hit_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            hit_q       <= hit_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign next_pc_out     = pc_q;
    assign instruction_out = instr_q;
    assign hit_out         = hit_q;

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Saturating counters; flush does not clear them.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (in_valid && !in_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (out_ready && !out_valid_q && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_pipe_buf.sv
// Bench for ifid_pipe_buf: directed scenarios plus random traffic against a
// queue-based reference model; a second DEPTH=1 instance covers full + pop.
module tb_ifid_pipe_buf;
    import pipe_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, hit, flush, out_valid, out_ready, hit_out;
    logic [31:0] next_pc, instruction, next_pc_out, instruction_out;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    logic        d1_in_valid, d1_in_ready, d1_hit, d1_flush, d1_out_valid, d1_out_ready, d1_hit_out;
    logic [31:0] d1_next_pc, d1_instruction, d1_next_pc_out, d1_instruction_out;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] d1_stall_cnt, d1_bubble_cnt;
`endif

    always #5 clk = ~clk;

    ifid_pipe_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .next_pc(next_pc), .instruction(instruction), .hit(hit),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .next_pc_out(next_pc_out), .instruction_out(instruction_out),
`ifdef IFID_PERF_CNT_EN
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
        .hit_out(hit_out)
    );

    ifid_pipe_buf #(.DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .next_pc(d1_next_pc), .instruction(d1_instruction), .hit(d1_hit),
        .flush(d1_flush),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .next_pc_out(d1_next_pc_out), .instruction_out(d1_instruction_out),
`ifdef IFID_PERF_CNT_EN
        .stall_cnt(d1_stall_cnt), .bubble_cnt(d1_bubble_cnt),
`endif
        .hit_out(d1_hit_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a bounded FIFO of entries plus the last head pc shown.
    ifid_entry_t mq[$];
    logic [31:0] m_last_pc;
    longint      m_stall, m_bubble;

    function automatic void model_reset();
        mq.delete();
        m_last_pc = '0;
        m_stall   = 0;
        m_bubble  = 0;
    endfunction

    function automatic void model_edge();
        int unsigned n  = mq.size();
        bit          rd = (n != DEPTH);
        bit          ps = in_valid && rd;
        bit          pp = out_ready && (n != 0);
        ifid_entry_t e;
        if (in_valid && !rd) m_stall++;
        if (out_ready && n == 0) m_bubble++;
        if (flush) begin
            mq.delete();
        end else begin
            if (pp) e = mq.pop_front();
            if (ps) begin
                e.pc = next_pc; e.instr = instruction; e.hit = hit;
                mq.push_back(e);
            end
        end
        if (mq.size() != 0) m_last_pc = mq[0].pc;
    endfunction

    task automatic compare();
        check_eq("in_ready", in_ready, mq.size() != DEPTH);
        check_eq("next_pc_out", next_pc_out, m_last_pc);
        if (mq.size() != 0) begin
            check_eq("out_valid", out_valid, 1'b1);
            check_eq("instruction_out", instruction_out, mq[0].instr);
            check_eq("hit_out", hit_out, mq[0].hit);
        end else begin
            check_eq("out_valid", out_valid, 1'b0);
            check_eq("instruction_out", instruction_out, NOP);
            check_eq("hit_out", hit_out, 1'b0);
        end
`ifdef IFID_PERF_CNT_EN
        check_eq("stall_cnt", stall_cnt, (m_stall > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stall);
        check_eq("bubble_cnt", bubble_cnt, (m_bubble > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bubble);
`endif
    endtask

    // Drive at posedge, DUT and model update at negedge, check at next posedge.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic h, input logic fl, input logic ordy);
        in_valid = iv; next_pc = pc; instruction = ins; hit = h; flush = fl; out_ready = ordy;
        @(negedge clk);
        model_edge();
        @(posedge clk);
        compare();
    endtask

    task automatic rand_step();
        step($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, $urandom,
             1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 0; next_pc = 0; instruction = 0; hit = 0; flush = 0; out_ready = 0;
        d1_in_valid = 0; d1_next_pc = 0; d1_instruction = 0; d1_hit = 0; d1_flush = 0; d1_out_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        compare();
        rst_n = 1'b1;

        // Fill to DEPTH with decode stalled, third push held off, then drain.
        step(1, 32'd4, 32'h0000_0413, 1, 0, 0);
        step(1, 32'd8, 32'h0000_0813, 0, 0, 0);
        check_eq("fill_in_ready", in_ready, 1'b0);
        step(1, 32'd12, 32'h0000_0c13, 1, 0, 0);
        check_eq("fill_head_pc", next_pc_out, 32'd4);
        step(0, 32'd0, 32'd0, 0, 0, 1);
        check_eq("drain_pc", next_pc_out, 32'd8);
        step(0, 32'd0, 32'd0, 0, 0, 1);
        check_eq("drain_empty", out_valid, 1'b0);

        // Streaming: one entry per cycle through a single slot.
        for (int i = 0; i < 10; i++) begin
            step(1, 32'h100 + 32'(4 * i), $urandom, 1'($urandom_range(0, 1)), 0, 1);
            check_eq("stream_pc", next_pc_out, 32'h100 + 32'(4 * i));
        end
        step(0, 32'd0, 32'd0, 0, 0, 1);

        // Flush with a concurrent push at count=2.
        step(1, 32'h200, 32'h1111_1111, 1, 0, 0);
        step(1, 32'h204, 32'h2222_2222, 1, 0, 0);
        step(1, 32'hDEAD, 32'h3333_3333, 1, 1, 0);
        check_eq("flush_valid", out_valid, 1'b0);
        check_eq("flush_nop", instruction_out, NOP);
        check_eq("flush_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'd0, 32'd0, 0, 0, 1);
            check_eq("flush_dropped", next_pc_out == 32'hDEAD, 1'b0);
        end

        // Empty decode right after reset: three bubbles.
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 32'd0, 32'd0, 0, 0, 1);
            check_eq("bubble_nop", instruction_out, NOP);
            check_eq("bubble_hit", hit_out, 1'b0);
        end
`ifdef IFID_PERF_CNT_EN
        check_eq("bubble_cnt3", bubble_cnt, 32'd3);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) rand_step();

        // Asynchronous reset mid-run takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_instr", instruction_out, NOP);
        check_eq("rst_ready", in_ready, 1'b1);
        model_reset();
        @(posedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) rand_step();

        // DEPTH=1: full + pop with in_valid does not accept until the next edge.
        d1_in_valid = 1; d1_next_pc = 32'h40; d1_instruction = 32'hAAAA_0001; d1_hit = 1; d1_out_ready = 0;
        @(negedge clk); @(posedge clk);
        check_eq("d1_valid", d1_out_valid, 1'b1);
        check_eq("d1_pc", d1_next_pc_out, 32'h40);
        check_eq("d1_full", d1_in_ready, 1'b0);
        d1_next_pc = 32'h44; d1_instruction = 32'hAAAA_0002; d1_hit = 0; d1_out_ready = 1;
        @(negedge clk); @(posedge clk);
        check_eq("d1_pop_valid", d1_out_valid, 1'b0);
        check_eq("d1_pop_nop", d1_instruction_out, NOP);
        check_eq("d1_pop_ready", d1_in_ready, 1'b1);
        d1_out_ready = 0;
        @(negedge clk); @(posedge clk);
        check_eq("d1_next_valid", d1_out_valid, 1'b1);
        check_eq("d1_next_pc", d1_next_pc_out, 32'h44);
        check_eq("d1_next_instr", d1_instruction_out, 32'hAAAA_0002);
`ifdef IFID_PERF_CNT_EN
        check_eq("d1_stall_cnt", d1_stall_cnt, 32'd1);
        check_eq("d1_bubble_cnt", d1_bubble_cnt, 32'd0);
`endif
        d1_in_valid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
